// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC result path: accumulator width,
// saturation limits and the stored result record.
package mac_pkg;

    localparam int MAC_WIDTH = 16;

    localparam logic signed [MAC_WIDTH-1:0] MAC_SAT_POS = 16'sh7FFF;
    localparam logic signed [MAC_WIDTH-1:0] MAC_SAT_NEG = 16'sh8000;

    typedef struct packed {
        logic                        ovf;
        logic signed [MAC_WIDTH-1:0] data;
    } mac_result_t;

    // A wrapped-negative sum came from a positive overflow, so clamp high; otherwise clamp low.
    function automatic mac_result_t mac_saturate(input logic signed [MAC_WIDTH-1:0] data,
                                                 input logic                        ovf);
        mac_result_t res;
        res.ovf = ovf;
        if (ovf) begin
            res.data = data[MAC_WIDTH-1] ? MAC_SAT_POS : MAC_SAT_NEG;
        end else begin
            res.data = data;
        end
        return res;
    endfunction

endpackage

// File: rtl/mac_sync_fifo.sv
// Generic synchronous FIFO with registered level/full/empty. Head entry is
// read combinationally from the storage array; reset clears storage too.
module mac_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 17,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [AW:0]   level_r;
    logic          full_r;
    logic          empty_r;

    logic          do_push_s;
    logic          do_pop_s;
    logic [AW:0]   level_next_s;

    // Qualify requests against the registered flags and work out next occupancy.
    always_comb begin
        do_push_s    = push & ~full_r;
        do_pop_s     = pop & ~empty_r;
        level_next_s = level_r;
        case ({do_push_s, do_pop_s})
            2'b10:   level_next_s = level_r + (AW+1)'(1);
            2'b01:   level_next_s = level_r - (AW+1)'(1);
            default: level_next_s = level_r;
        endcase
    end

    // Storage, pointers and occupancy flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wptr_r  <= '0;
            rptr_r  <= '0;
            level_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            if (do_push_s) begin
                mem_r[wptr_r] <= wdata;
                wptr_r        <= wptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + AW'(1);
            end
            level_r <= level_next_s;
            full_r  <= (level_next_s == (AW+1)'(DEPTH));
            empty_r <= (level_next_s == (AW+1)'(0));
        end
    end

    assign rdata = mem_r[rptr_r];
    assign full  = full_r;
    assign empty = empty_r;
    assign level = level_r;

endmodule

// File: rtl/mac_result_buffer.sv
// Buffers MAC accumulator results in a FIFO with drop counting and a sticky
// overflow flag. Define MAC_RESULT_SAT_EN to store overflowed results saturated.
module mac_result_buffer
    import mac_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = MAC_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_ovf,
    input  logic                     out_ready,
    input  logic                     clr_status,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_ovf,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf_sticky,
    output logic [CNT_W-1:0]         drop_cnt
);

    logic [WIDTH:0]   wdata_s;
    logic [WIDTH:0]   rdata_s;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             drop_s;
    logic             ovf_sticky_r;
    logic [CNT_W-1:0] drop_cnt_r;
`ifdef MAC_RESULT_SAT_EN
    mac_result_t      sat_s;
`endif

    // A push while full is rejected against the registered full, even if a pop frees a slot.
    always_comb begin
        push_s = in_valid & ~full_s;
        drop_s = in_valid & full_s;
        pop_s  = ~empty_s & out_ready;
    end

    // Build the stored entry; the overflow tag is always kept alongside the data.
    always_comb begin
`ifdef MAC_RESULT_SAT_EN
        sat_s   = mac_saturate(MAC_WIDTH'(in_data), in_ovf);
        wdata_s = {in_ovf, WIDTH'(sat_s.data)};
`else
        wdata_s = {in_ovf, in_data};
`endif
    end

    mac_sync_fifo #(
        .DEPTH (DEPTH),
        .DW    (WIDTH + 1)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (wdata_s),
        .rdata (rdata_s),
        .full  (full_s),
        .empty (empty_s),
        .level (level)
    );

    // Sticky status: a set in the same cycle as a clear wins, and a drop during a clear counts as one.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_sticky_r <= 1'b0;
            drop_cnt_r   <= '0;
        end else begin
            ovf_sticky_r <= (push_s & in_ovf) | (ovf_sticky_r & ~clr_status);
            if (clr_status) begin
                drop_cnt_r <= CNT_W'(drop_s);
            end else if (drop_s && (drop_cnt_r != {CNT_W{1'b1}})) begin
                drop_cnt_r <= drop_cnt_r + CNT_W'(1);
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    assign out_valid  = ~empty_s;
    assign out_data   = rdata_s[WIDTH-1:0];
    assign out_ovf    = rdata_s[WIDTH];
    assign full       = full_s;
    assign ovf_sticky = ovf_sticky_r;
    assign drop_cnt   = drop_cnt_r;

endmodule

// File: tb/tb_mac_result_buffer.sv
// Self-checking bench for mac_result_buffer: queue-based reference model,
// per-cycle compare process, directed scenarios and randomized traffic.
module tb_mac_result_buffer;

    localparam int DEPTH = 4;
    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ovf = 1'b0;
    logic             out_ready = 1'b0;
    logic             clr_status = 1'b0;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;
    logic             full;
    logic [2:0]       level;
    logic             ovf_sticky;
    logic [CNT_W-1:0] drop_cnt;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [WIDTH:0] mq[$];
    int             m_drop = 0;
    bit             m_sticky = 1'b0;

    mac_result_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ovf     (in_ovf),
        .out_ready  (out_ready),
        .clr_status (clr_status),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ovf    (out_ovf),
        .full       (full),
        .level      (level),
        .ovf_sticky (ovf_sticky),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] stored_value(input logic [WIDTH-1:0] d, input logic o);
`ifdef MAC_RESULT_SAT_EN
        if (o) return d[WIDTH-1] ? 16'h7FFF : 16'h8000;
`endif
        return d;
    endfunction

    // Advance the model by one clock using the inputs that were applied for it.
    task automatic model_step();
        bit was_full;
        bit do_push;
        bit do_pop;
        bit do_drop;
        if (reset) begin
            mq.delete();
            m_drop = 0;
            m_sticky = 1'b0;
            return;
        end
        was_full = (mq.size() == DEPTH);
        do_pop   = (mq.size() != 0) && out_ready;
        do_push  = in_valid && !was_full;
        do_drop  = in_valid && was_full;
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back({in_ovf, stored_value(in_data, in_ovf)});
        if (do_push && in_ovf) m_sticky = 1'b1;
        else if (clr_status) m_sticky = 1'b0;
        if (clr_status) m_drop = do_drop ? 1 : 0;
        else if (do_drop && m_drop < 255) m_drop++;
    endtask

    task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic o,
                       input logic r, input logic c, input logic rs);
        @(negedge clk);
        in_valid = v; in_data = d; in_ovf = o; out_ready = r; clr_status = c; reset = rs;
        @(posedge clk);
        #1;
        model_step();
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            check("level", 32'(level), 32'(mq.size()));
            check("full", 32'(full), 32'(mq.size() == DEPTH));
            check("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
            check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            if (mq.size() != 0) begin
                check("out_data", 32'(out_data), 32'(mq[0][WIDTH-1:0]));
                check("out_ovf", 32'(out_ovf), 32'(mq[0][WIDTH]));
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] exp_sat;

        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_sticky", 32'(ovf_sticky), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);

        // Three pushes held, then drained in order
        cyc(1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lat_out_valid", 32'(out_valid), 32'd1);
        cyc(1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'd14, 1'b0, 1'b0, 1'b0, 1'b0);
        check("level3", 32'(level), 32'd3);
        check("head1", 32'(out_data), 32'd1);
        cyc(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("head5", 32'(out_data), 32'd5);
        cyc(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("head14", 32'(out_data), 32'd14);
        cyc(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("drained_valid", 32'(out_valid), 32'd0);
        cyc(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("empty_ready_level", 32'(level), 32'd0);

        // Fill, overfill by two, then push+pop while full
        for (int i = 0; i < 6; i++) cyc(1'b1, 16'(10 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_drop", 32'(drop_cnt), 32'd2);
        check("fill_head", 32'(out_data), 32'd10);
        cyc(1'b1, 16'd30, 1'b0, 1'b1, 1'b0, 1'b0);
        check("fullpp_level", 32'(level), 32'd3);
        check("fullpp_drop", 32'(drop_cnt), 32'd3);
        check("fullpp_head", 32'(out_data), 32'd11);
        for (int i = 0; i < 4; i++) cyc(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Overflowed entry
        cyc(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("clr_drop", 32'(drop_cnt), 32'd0);
        cyc(1'b1, 16'h8002, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef MAC_RESULT_SAT_EN
        exp_sat = 16'h7FFF;
`else
        exp_sat = 16'h8002;
`endif
        check("ovf_sticky", 32'(ovf_sticky), 32'd1);
        check("ovf_tag", 32'(out_ovf), 32'd1);
        check("ovf_data", 32'(out_data), 32'(exp_sat));
        cyc(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // drop_cnt=5, then clear together with an overflowed push
        for (int i = 0; i < 9; i++) cyc(1'b1, 16'(100 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        check("drop5", 32'(drop_cnt), 32'd5);
        cyc(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'h7000, 1'b1, 1'b0, 1'b1, 1'b0);
        check("clrset_sticky", 32'(ovf_sticky), 32'd1);
        check("clrset_drop", 32'(drop_cnt), 32'd0);
        cyc(1'b1, 16'd200, 1'b0, 1'b0, 1'b1, 1'b0);
        check("clrdrop_cnt", 32'(drop_cnt), 32'd1);
        check("clr_sticky", 32'(ovf_sticky), 32'd0);

        // drop_cnt saturation
        for (int i = 0; i < 260; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        check("drop_sat", 32'(drop_cnt), 32'd255);
        for (int i = 0; i < 4; i++) cyc(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset mid-operation
        cyc(1'b1, 16'd41, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'd42, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("mrst_level", 32'(level), 32'd0);
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_drop", 32'(drop_cnt), 32'd0);
        cyc(1'b1, 16'd77, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mrst_push_valid", 32'(out_valid), 32'd1);
        check("mrst_push_data", 32'(out_data), 32'd77);
        cyc(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 5) == 0),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 30) == 0),
                1'($urandom_range(0, 400) == 0));
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_result_buffer.md
# mac_result_buffer

Downstream stage of the signed 8x8 multiply-accumulate unit. Captures each accumulator result (`f`, `overflow`) qualified by the MAC's `valid_out`, optionally saturates overflowed results, and queues them in a small FIFO. Results are presented to the consumer over a valid/ready handshake, so a stalled consumer never forces the MAC to stop. Drops and overflows are reported through sticky status registers.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; must be a power of 2 and at least 2.
- `WIDTH`, 16: result width; matches the MAC accumulator.
- `CNT_W`, 8: width of the drop counter.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  driven by the MAC `valid_out`.
- `in_data`  in  WIDTH  driven by the MAC `f`; signed.
- `in_ovf`  in  1  driven by the MAC `overflow`.
- `out_ready`  in  1  consumer can accept the head entry.
- `clr_status`  in  1  clears `ovf_sticky` and `drop_cnt`.
- `out_valid`  out  1  head entry is available.
- `out_data`  out  WIDTH  head result.
- `out_ovf`  out  1  overflow tag of the head entry.
- `full`  out  1  occupancy equals DEPTH.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `ovf_sticky`  out  1  an overflowed result has been accepted since the last clear.
- `drop_cnt`  out  CNT_W  number of results lost while full.

## Operation
- Reset values:
  - `out_valid`, `full`, `ovf_sticky` = 0.
  - `level`, `drop_cnt` = 0.
  - `out_data`, `out_ovf` = 0.
  - Read and write pointers = 0.
- Write (push):
  - Occurs when `in_valid` is high and `full` is low.
  - Stores `{in_ovf, data}`, where `data` comes from the saturation rule below.
  - The write pointer increments modulo DEPTH.
- Read (pop):
  - Occurs when `out_valid` and `out_ready` are both high.
  - The read pointer increments modulo DEPTH.
- Drop:
  - Occurs when `in_valid` is high and `full` is high.
  - The entry is discarded and `drop_cnt` increments, saturating at 2^CNT_W−1.
- Push and pop in the same cycle when not full and not empty: both happen and `level` is unchanged.
- Push while full with a simultaneous pop:
  - The push is rejected, because `full` is the registered value.
  - The pop proceeds and the drop is counted.
- Push while empty: there is no bypass; the entry appears on the next cycle.
- `out_valid` = (`level` != 0).
- `out_data` and `out_ovf` show the head entry combinationally from the register array. When empty they hold the last value and are don't-care to the consumer.
- `ovf_sticky`:
  - Set when an accepted entry has `in_ovf` = 1.
  - Cleared by `clr_status`.
  - If set and clear occur in the same cycle, set wins.
- `drop_cnt`:
  - Cleared by `clr_status`.
  - If a drop and a clear occur in the same cycle, the result is 1.
- Reset mid-operation empties the FIFO immediately on that edge. The contents are lost and are not counted as drops.

## Timing
- Latency from a `in_valid` edge to `out_valid` = 1 cycle (registered).
- Sustained throughput is 1 result per cycle when `out_ready` is held high.
- `full` and `level` update on the same edge as the push or pop that changes them.
- Holding `out_ready` high while empty has no effect.

## Configuration
- Macro `MAC_RESULT_SAT_EN`.
- Defined: an entry with `in_ovf` = 1 is stored as a saturated value.
  - 16'sh7FFF when `in_data[WIDTH-1]` = 1 (the sum wrapped negative).
  - 16'sh8000 otherwise.
  - `out_ovf` still reports 1 for that entry.
- Undefined: `in_data` is stored unmodified and the overflow is reported via the tag only.

## Structure
- Package `mac_pkg` holds:
  - `MAC_WIDTH` = 16.
  - `MAC_SAT_POS` and `MAC_SAT_NEG` constants.
  - Typedef `mac_result_t` (packed struct `{logic ovf; logic signed [15:0] data}`).
- Sub-module `mac_sync_fifo`: a generic synchronous FIFO with pointers, level and full/empty. `mac_result_buffer` wraps it with the saturation, drop and sticky logic.

## Test plan
- Reset, then push 3 (`in_valid` with data 1, 5, 14) with `out_ready` = 0 → `level` = 3; then `out_ready` = 1 → `out_data` reads 1, 5, 14 on consecutive cycles and `out_valid` falls after the third.
- Fill to DEPTH = 4, then push 2 more with `out_ready` = 0 → `full` = 1, `drop_cnt` = 2, and the stored contents are unchanged.
- With the FIFO full, assert push and pop in the same cycle → `level` 4→3, `drop_cnt` increments, and the head advances.
- Push `in_data` = 16'h8002 with `in_ovf` = 1 → `ovf_sticky` = 1 and `out_ovf` = 1. `out_data` = 16'h7FFF with `MAC_RESULT_SAT_EN` defined, 16'h8002 without.
- With `ovf_sticky` = 1 and `drop_cnt` = 5, pulse `clr_status` together with a new overflowed push → `ovf_sticky` stays 1 and `drop_cnt` = 0.
- Fill with 2 entries, assert `reset` for one cycle → `level` = 0, `out_valid` = 0, `drop_cnt` = 0; a following push appears 1 cycle later.
